// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: state encoding,
// opcode/funct constants, datapath select codes and the instruction decoder.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MDWAIT = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;
  localparam logic [1:0] M2R_HILO = 2'b11;

  typedef enum logic [4:0] {
    I_NOP, I_ADDU, I_SUBU, I_OR, I_XOR, I_ORI, I_LUI, I_LW, I_SW,
    I_BEQ, I_J, I_JAL, I_JR, I_MULT, I_DIV, I_MFHI, I_MFLO
  } instr_e;

  // Anything outside the supported subset collapses to I_NOP.
  function automatic instr_e decode_instr(input logic [5:0] op, input logic [5:0] func);
    instr_e i;
    i = I_NOP;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: i = I_ADDU;
          FN_SUBU: i = I_SUBU;
          FN_OR:   i = I_OR;
          FN_XOR:  i = I_XOR;
          FN_JR:   i = I_JR;
          FN_MULT: i = I_MULT;
          FN_DIV:  i = I_DIV;
          FN_MFHI: i = I_MFHI;
          FN_MFLO: i = I_MFLO;
          default: i = I_NOP;
        endcase
      end
      OP_ORI:  i = I_ORI;
      OP_LUI:  i = I_LUI;
      OP_LW:   i = I_LW;
      OP_SW:   i = I_SW;
      OP_BEQ:  i = I_BEQ;
      OP_J:    i = I_J;
      OP_JAL:  i = I_JAL;
      default: i = I_NOP;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/multicycle_controller_md_counter.sv
// Load/decrement latency counter used to time the mult/div wait state.
module md_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             at_one
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_one = (count_q == CNT_W'(1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller FSM: FETCH/DECODE/EXEC/MEM/WB plus a mult/div wait state,
// producing datapath strobes and selects combinationally from state and IR fields.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               HiLoStart,
  output logic [1:0]         PCsrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               HiLoSel,
  output logic               ALUsrc,
  output logic               sign,
  output logic [ALUOP_W-1:0] ALUControl,
  output logic               busy,
  output logic [2:0]         state
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

  state_e state_q;
  state_e state_d;
  instr_e instr;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_at_one;

  logic       ir_write, pc_write, mem_write, reg_write, hilo_start;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic       hilo_sel, alu_src, sign_ext, md_busy;
  logic [2:0] alu_code;

  assign instr = decode_instr(op, func);

  md_counter #(.CNT_W(CNT_W)) u_md_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .at_one   (cnt_at_one)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    hilo_start   = 1'b0;
    pc_src       = PC_SEQ;
    reg_dst      = RD_RT;
    mem_to_reg   = M2R_ALU;
    hilo_sel     = 1'b0;
    alu_src      = 1'b0;
    sign_ext     = 1'b0;
    md_busy      = 1'b0;
    alu_code     = ALU_ADD;

    case (state_q)
      ST_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_SEQ;
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
        case (instr)
          I_J: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = ST_FETCH;
          end
          I_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            reg_write  = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = M2R_PC4;
            state_d    = ST_FETCH;
          end
          I_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_REG;
            state_d  = ST_FETCH;
          end
          I_NOP:   state_d = ST_FETCH;
          default: ;
        endcase
      end

      ST_EXEC: begin
        state_d = ST_WB;
        case (instr)
          I_SUBU: alu_code = ALU_SUB;
          I_OR:   alu_code = ALU_OR;
          I_XOR:  alu_code = ALU_XOR;
          I_ORI: begin
            alu_code = ALU_OR;
            alu_src  = 1'b1;
          end
          I_LUI: begin
            alu_code = ALU_LUI;
            alu_src  = 1'b1;
          end
          I_LW, I_SW: begin
            alu_src  = 1'b1;
            sign_ext = 1'b1;
            state_d  = ST_MEM;
          end
          I_BEQ: begin
            alu_code = ALU_SUB;
            sign_ext = 1'b1;
            pc_src   = PC_BRANCH;
            pc_write = zero;
            state_d  = ST_FETCH;
          end
          I_MULT, I_DIV: begin
            hilo_start   = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = (instr == I_MULT) ? MULT_LOAD : DIV_LOAD;
            state_d      = ST_MDWAIT;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        if (instr == I_SW) begin
          mem_write = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
        case (instr)
          I_ADDU, I_SUBU, I_OR, I_XOR: reg_dst = RD_RD;
          I_LW: mem_to_reg = M2R_MEM;
          I_MFHI, I_MFLO: begin
            reg_dst    = RD_RD;
            mem_to_reg = M2R_HILO;
            hilo_sel   = (instr == I_MFHI);
          end
          default: ;
        endcase
      end

      // Counter was loaded with LAT in EXEC, so leaving at 1 gives LAT cycles here.
      ST_MDWAIT: begin
        md_busy = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_at_one) state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: reset is synchronous; only the state and counter flops need clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low for as long as reset is held.
  always_comb begin
    IRWrite    = reset & ir_write;
    PCWrite    = reset & pc_write;
    MemWrite   = reset & mem_write;
    RegWrite   = reset & reg_write;
    HiLoStart  = reset & hilo_start;
    PCsrc      = reset ? pc_src : 2'b00;
    RegDst     = reset ? reg_dst : 2'b00;
    MemtoReg   = reset ? mem_to_reg : 2'b00;
    HiLoSel    = reset & hilo_sel;
    ALUsrc     = reset & alu_src;
    sign       = reset & sign_ext;
    ALUControl = reset ? ALUOP_W'(alu_code) : '0;
    busy       = reset & md_busy;
    state      = reset ? state_q : 3'd0;
  end

endmodule
